// File: rtl/register_file_sb_pkg.sv
// rf_pkg: shared constants and address-width helper for the register file
package rf_pkg;
    localparam int ZERO_IDX = 0;
    localparam logic RST_BIT = 1'b0;
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/register_file_sb_if.sv
// register_file_sb_if: decode/writeback bus of the scoreboarded register file
interface register_file_sb_if
    import rf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_REGS = 4
);
    localparam int ADDR_W = addr_w(NUM_REGS);
    logic [ADDR_W-1:0] RR1, RR2, WR, ResvReg;
    logic [DATA_W-1:0] RD1, RD2, WD;
    logic RegWrite, ResvEn, Busy1, Busy2, Stall;
    modport master(
        output RR1, RR2, RegWrite, WR, WD, ResvEn, ResvReg,
        input RD1, RD2, Busy1, Busy2, Stall
    );
    modport slave(
        input RR1, RR2, RegWrite, WR, WD, ResvEn, ResvReg,
        output RD1, RD2, Busy1, Busy2, Stall
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// rf_scoreboard: per-register pending-write bits and read-hazard flags
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W = addr_w(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_reg,
    output logic              busy1,
    output logic              busy2,
    output logic              stall
);
    logic [NUM_REGS-1:0] pending, pending_nxt;
    // a new reservation beats a same-cycle writeback; a hardwired zero reg is never pending
    always_comb begin
        pending_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++)
            pending_nxt[r] = (ZERO_REG && r == ZERO_IDX) ? 1'b0 :
                             (resv_en && resv_reg == ADDR_W'(r)) |
                             (pending[r] & ~(reg_write && wr == ADDR_W'(r)));
    end
    // pending bits register
    always_ff @(posedge clock) begin
        if (!reset_n) pending <= '0;
        else pending <= pending_nxt;
    end
    // a writeback this cycle resolves the hazard through the read bypass
    always_comb begin
        busy1 = pending[rr1] && !(reg_write && wr == rr1);
        busy2 = pending[rr2] && !(reg_write && wr == rr2);
        stall = busy1 | busy2;
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: 2R/1W register file with write bypass and pending-write scoreboard
module register_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_REGS = 4,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W = addr_w(NUM_REGS)
) (
    input logic clock,
    input logic reset_n,
    register_file_sb_if.slave bus
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic we;
    assign we = bus.RegWrite && !(ZERO_REG && bus.WR == ADDR_W'(ZERO_IDX));
    // storage: reset clears every register, otherwise one write per cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= {DATA_W{RST_BIT}};
        end else if (we) begin
            regs[bus.WR] <= bus.WD;
        end
    end
    // read muxes: hardwired zero first, then same-cycle write bypass, then storage
    always_comb begin
        bus.RD1 = (ZERO_REG && bus.RR1 == ADDR_W'(ZERO_IDX)) ? '0 :
                  (we && bus.WR == bus.RR1) ? bus.WD : regs[bus.RR1];
        bus.RD2 = (ZERO_REG && bus.RR2 == ADDR_W'(ZERO_IDX)) ? '0 :
                  (we && bus.WR == bus.RR2) ? bus.WD : regs[bus.RR2];
    end
    rf_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
        .clock(clock),
        .reset_n(reset_n),
        .rr1(bus.RR1),
        .rr2(bus.RR2),
        .reg_write(bus.RegWrite),
        .wr(bus.WR),
        .resv_en(bus.ResvEn),
        .resv_reg(bus.ResvReg),
        .busy1(bus.Busy1),
        .busy2(bus.Busy2),
        .stall(bus.Stall)
    );
endmodule
